// File: rtl/piso_pkg.sv
// piso_pkg: shared definitions for the parallel-in/serial-out stage.
//   - piso_state_e : one-hot FSM states (ST_IDLE, ST_SHIFT, ST_PARITY)
//   - PISO_WIDTH_DEFAULT / PISO_IDLE_BIT_DEFAULT : parameter defaults
//   - even_parity() : XOR reduction of a (zero-extended) word
package piso_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_SHIFT  = 3'b010,
    ST_PARITY = 3'b100
  } piso_state_e;

  localparam int unsigned PISO_WIDTH_DEFAULT    = 8;
  localparam logic        PISO_IDLE_BIT_DEFAULT = 1'b0;

  // Zero-extension does not change an XOR reduction, so any word up to
  // 32 bits can be passed in.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// piso_hold_buf: one-entry holding register in front of the shifter.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_data         parallel word offered upstream
//   in_valid        in_data is valid
//   in_ready        buffer empty and not in reset (accept = in_valid && in_ready)
//   bypass          shifter is at a word boundary and takes the accepted word
//                   directly, so it must not be captured here
//   consume         shifter loads the held word at this edge
//   hold_data       held word
//   hold_valid      a word is held
module piso_hold_buf
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bypass,
  input  logic             consume,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_valid
);

  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             accept;

  assign in_ready   = !hold_valid_q && !rst;
  assign accept     = in_valid && in_ready;
  assign hold_data  = hold_data_q;
  assign hold_valid = hold_valid_q;

  // Accept only happens while empty, so capture and consume never collide.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (consume) begin
      hold_valid_d = 1'b0;
    end
    if (accept && !bypass) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: accepts WIDTH-bit words over valid/ready and emits them
// one bit per clock, MSB first, with a one-entry holding buffer so that
// back-to-back words stream without gaps. Drives IDLE_BIT when idle.
// Optional feature (macro PISO_PARITY_EN): one even-parity bit follows the
// LSB of every word, making the word period WIDTH+1.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_data      parallel word
//   in_valid     in_data valid
//   in_ready     stage can accept (= !hold_valid && !rst)
//   dout         registered serial bit
//   dout_valid   dout carries a word (or parity) bit
//   sof          dout is the MSB of a word
//
// state     | meaning
// ST_IDLE   | no word in flight, dout = IDLE_BIT
// ST_SHIFT  | shifting a word, cnt = bits remaining after the one shown
// ST_PARITY | parity bit shown (PISO_PARITY_EN only)
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH    = PISO_WIDTH_DEFAULT,
  parameter logic        IDLE_BIT = PISO_IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             sof
);

  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             sof_q, sof_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;
  logic             accept;
  logic             boundary;
  logic             consume;
  logic             load;
  logic [WIDTH-1:0] load_word;

  piso_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bypass     (boundary),
    .consume    (consume),
    .hold_data  (hold_data),
    .hold_valid (hold_valid)
  );

  assign accept    = in_valid && in_ready;
  // A held word always wins; in_ready is low whenever one is held.
  assign load_word = hold_valid ? hold_data : in_data;

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    sof_d        = sof_q;
`ifdef PISO_PARITY_EN
    par_d        = par_q;
`endif
    boundary     = 1'b0;
    consume      = 1'b0;
    load         = 1'b0;

    case (state_q)
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          sh_d         = sh_q << 1;
          dout_d       = sh_d[WIDTH-1];
          cnt_d        = cnt_q - CW'(1);
          dout_valid_d = 1'b1;
          sof_d        = 1'b0;
        end else begin
`ifdef PISO_PARITY_EN
          state_d      = ST_PARITY;
          dout_d       = par_q;
          dout_valid_d = 1'b1;
          sof_d        = 1'b0;
`else
          boundary     = 1'b1;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: boundary = 1'b1;
`endif
      // ST_IDLE and any illegal encoding recover through a word boundary.
      default:   boundary = 1'b1;
    endcase

    if (boundary) begin
      if (hold_valid) begin
        consume = 1'b1;
        load    = 1'b1;
      end else if (accept) begin
        load    = 1'b1;
      end

      if (load) begin
        sh_d         = load_word;
        dout_d       = load_word[WIDTH-1];
        cnt_d        = CNT_LAST;
        sof_d        = 1'b1;
        dout_valid_d = 1'b1;
        state_d      = ST_SHIFT;
`ifdef PISO_PARITY_EN
        par_d        = even_parity(32'(load_word));
`endif
      end else begin
        dout_d       = IDLE_BIT;
        dout_valid_d = 1'b0;
        sof_d        = 1'b0;
        state_d      = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= IDLE_BIT;
      dout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sof_q        <= sof_d;
`ifdef PISO_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sof        = sof_q;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int P = W + 1;
`else
  localparam int P = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;

  logic in_ready0, dout0, dv0, sof0;
  logic in_ready1, dout1, dv1, sof1;

  piso_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .dout(dout0), .dout_valid(dv0), .sof(sof0)
  );

  piso_serializer #(.WIDTH(W), .IDLE_BIT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .dout(dout1), .dout_valid(dv1), .sof(sof1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position within the current word (0..P-1), the word
  // itself, and an optional waiting word. A word starts whenever the previous
  // one has shown all P bits (or nothing is running).
  bit           m_busy = 0;
  bit           m_held = 0;
  bit           m_acc;
  int           m_idx = 0;
  logic [W-1:0] m_cur = '0;
  logic [W-1:0] m_hw = '0;

  always @(posedge clk) begin
    m_acc = in_valid && !m_held && !rst;
    if (rst) begin
      m_busy = 0;
      m_held = 0;
      m_idx  = 0;
    end else if (m_busy && m_idx < P - 1) begin
      m_idx++;
      if (m_acc) begin
        m_held = 1;
        m_hw   = in_data;
      end
    end else if (m_held) begin
      m_cur  = m_hw;
      m_held = 0;
      m_busy = 1;
      m_idx  = 0;
    end else if (m_acc) begin
      m_cur  = in_data;
      m_busy = 1;
      m_idx  = 0;
    end else begin
      m_busy = 0;
    end
  end

  function automatic logic exp_dout(input logic idle);
    if (!m_busy) return idle;
    if (m_idx < W) return m_cur[W-1-m_idx];
    return ^m_cur;
  endfunction

  bit   cmp_en = 0;
  logic data_q[$];
  logic par_q[$];
  int   pos = 0;
  int   dv1_cnt = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready0", in_ready0, !m_held && !rst);
      chk("dout0", dout0, exp_dout(1'b0));
      chk("dv0", dv0, m_busy);
      chk("sof0", sof0, m_busy && m_idx == 0);
      chk("in_ready1", in_ready1, !m_held && !rst);
      chk("dout1", dout1, exp_dout(1'b1));
      chk("dv1", dv1, m_busy);
      chk("sof1", sof1, m_busy && m_idx == 0);
    end
    if (dv0) begin
      if (sof0) pos = 0;
      else pos++;
      if (pos < W) data_q.push_back(dout0);
      else par_q.push_back(dout0);
    end
    if (dv1) dv1_cnt++;
  end

  function automatic logic [31:0] pack(input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n && i < data_q.size(); i++) v = {v[30:0], data_q[i]};
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_streams();
    data_q.delete();
    par_q.delete();
    dv1_cnt = 0;
  endtask

  // Offers w until accepted; leaves in_valid high so callers can stream.
  task automatic send(input logic [W-1:0] w);
    bit r;
    bit ok;
    in_data  = w;
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 4 * P; i++) begin
      @(negedge clk);
      r = in_ready0;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: word %0h not accepted, in_ready=%0b", w, in_ready0);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    cmp_en = 1;
    tick(2);
    rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_dout", dout0, 0);
      chk("idle_dv", dv0, 0);
      chk("idle_sof", sof0, 0);
      chk("idle_ready", in_ready0, 1);
    end
    @(posedge clk);
    #1;

    // continuous 8'hAA
    clear_streams();
    in_data  = 8'hAA;
    in_valid = 1'b1;
    tick(3 * P + 2);
    in_valid = 1'b0;
    tick(3 * P);
    chk("aa_min_len", data_q.size() >= 24, 1);
    chk("aa_len_mod", data_q.size() % 8, 0);
    chk("aa_first16", pack(16), 32'h0000_AAAA);

    // three words back to back
    clear_streams();
    send(8'hF0);
    send(8'h0F);
    send(8'h81);
    in_valid = 1'b0;
    tick(3 * P);
    chk("f00f81_len", data_q.size(), 24);
    chk("f00f81_bits", pack(24), 32'h00F0_0F81);

    // reset after third bit of 8'hC3
    clear_streams();
    send(8'hC3);
    in_valid = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dout", dout0, 0);
    chk("rst_dv", dv0, 0);
    chk("rst_ready", in_ready0, 1);
    chk("rst_dout_idle1", dout1, 1);
    tick(2 * P);
    chk("c3_len", data_q.size(), 3);
    chk("c3_bits", pack(3), 32'h6);

    // single 8'h00 seen through IDLE_BIT=1 instance
    clear_streams();
    @(negedge clk);
    chk("z_pre_dout1", dout1, 1);
    @(posedge clk);
    #1;
    send(8'h00);
    in_valid = 1'b0;
    tick(2 * P);
    @(negedge clk);
    chk("z_post_dout1", dout1, 1);
    chk("z_post_dv1", dv1, 0);
    chk("z_dv1_cycles", dv1_cnt, P);
    chk("z_len", data_q.size(), 8);
    chk("z_bits", pack(8), 32'h0);
    @(posedge clk);
    #1;

    // A8 then 03 back to back (parity bits when enabled)
    clear_streams();
    send(8'hA8);
    send(8'h03);
    in_valid = 1'b0;
    tick(3 * P);
    chk("a803_len", data_q.size(), 16);
    chk("a803_bits", pack(16), 32'h0000_A803);
`ifdef PISO_PARITY_EN
    chk("par_len", par_q.size(), 2);
    if (par_q.size() == 2) begin
      chk("par_a8", par_q[0], 1);
      chk("par_03", par_q[1], 0);
    end
`endif

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom);
      rst      = ($urandom_range(0, 79) == 0);
      tick(1);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    tick(3 * P);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the bit-serial sequence detector and drives its `din` input.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, MSB first.
- A one-entry holding buffer lets back-to-back words stream with no idle gaps.
- When no word is in flight, it drives a defined idle level so the detector always sees a clean bit every cycle.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..32).
- IDLE_BIT, 1'b0, level driven on `dout` while no word is being shifted.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  parallel word to serialize
- in_valid  input  1  `in_data` is valid
- in_ready  output  1  stage can accept a word; equals `!hold_valid && !rst`
- dout  output  1  registered serial bit; connects to the detector's `din`
- dout_valid  output  1  `dout` carries a word bit (registered)
- sof  output  1  `dout` is bit 0 of a word, i.e. the word's MSB (registered)

Behaviour:
- Interface (already decided): one clock, `clk`. Reset `rst` is synchronous and active-high; it is sampled only on the rising edge of `clk`.
- Reset values: `dout` = IDLE_BIT, `dout_valid` = 0, `sof` = 0, `hold_valid` = 0, counter = 0, state = IDLE.
- `in_ready` is 0 while `rst` is high. It is 1 in the first cycle after reset is released.
- A word is accepted at a clock edge where `in_valid && in_ready`.
- Internal registers:
  - shift register `sh[WIDTH-1:0]`
  - down-counter `cnt` (width `$clog2(WIDTH)`) = bits remaining after the current one
  - `hold_data` and `hold_valid`
  - one-hot state: IDLE, SHIFT, PARITY. PARITY exists only with the optional feature.
- The state machine evaluates each edge as follows:
  - SHIFT with `cnt` > 0: shift `sh` left; `dout` <= next bit; `cnt`--; `dout_valid` = 1; `sof` = 0.
  - IDLE, or SHIFT with `cnt` == 0 (last bit currently shown): this is a word boundary.
  - At a word boundary, the next word is taken from `hold_data` if `hold_valid` is set.
  - Otherwise it is taken directly from `in_data` if a word is accepted at this edge (bypass).
  - If a word is available: load `sh`; `dout` <= word[WIDTH-1]; `cnt` <= WIDTH-1; `sof` <= 1; `dout_valid` <= 1; state <= SHIFT.
  - If no word is available: `dout` <= IDLE_BIT; `dout_valid` <= 0; `sof` <= 0; state <= IDLE.
- Latency: a word accepted at edge k while the stage is idle shows its MSB on `dout` after edge k (bypass path). Its LSB appears after edge k+WIDTH-1.
- Holding buffer:
  - A word accepted at an edge that is not a word boundary goes into `hold_data`, and `hold_valid` <= 1.
  - `hold_valid` clears at the boundary where the held word is loaded.
  - Because `in_ready` = `!hold_valid`, accept and hold-consume never coincide at the same edge.
- Throughput: continuous `in_valid` gives gapless output, one word per WIDTH cycles. `in_ready` deasserts for WIDTH-1 cycles per word.
- `in_data` is sampled only on acceptance. Changes while `in_ready` = 0 are ignored.
- Reset mid-word: the in-flight word and the held word are discarded. Output returns to idle on the next edge. No partial word is resumed.

Optional Feature:
- Macro: PISO_PARITY_EN.
- When defined: after the LSB, the block spends one extra cycle in PARITY.
  - In that cycle `dout` = XOR of the word (even parity), `dout_valid` = 1, `sof` = 0.
  - The word boundary check moves to the PARITY cycle, so the word period is WIDTH+1.
- When undefined: there is no PARITY state, and the word period is WIDTH.

Decomposition:
- Package `piso_pkg` holds:
  - one-hot state constants ST_IDLE, ST_SHIFT, ST_PARITY (3 bits)
  - default WIDTH and IDLE_BIT constants
  - even-parity function.
- Sub-module `piso_hold_buf` is the one-entry holding register, with in_valid/in_ready on its input side and a consume strobe on its output side. The shifter FSM stays in the top level.

Test Plan:
- Reset released, `in_valid` = 0 for 10 cycles -> `dout` = 0, `dout_valid` = 0, `sof` = 0, `in_ready` = 1 throughout.
- Reset released, word 8'hAA accepted at edge k, 8'hAA offered continuously afterwards -> `dout` = 1,0,1,0,… for 16+ consecutive cycles with no gap. `sof` pulses every 8 cycles. The downstream detector's flag fires after the eighth bit.
- Three words 8'hF0, 8'h0F, 8'h81 held valid continuously -> serial stream 11110000_00001111_10000001. `in_ready` is low for 7 of every 8 cycles. No word is lost or duplicated.
- Word 8'hC3 accepted, `rst` asserted after the third bit, then released -> `dout` = IDLE_BIT and `dout_valid` = 0 on the edge after reset. `in_ready` returns to 1. The remaining bits are never emitted.
- IDLE_BIT = 1, single word 8'h00 -> `dout` = 1 before the word, 00000000 during it, and 1 afterwards. `dout_valid` is high only for the 8 data cycles.
- PISO_PARITY_EN defined, word 8'hA8 -> bits 10101000 followed by a parity bit of 1. The next back-to-back word 8'h03 starts on cycle 10 with parity bit 0.
